// File: rtl/rw_mapped_ram.sv
// Single-port RAM mapped into a bus address window [BASE, BASE+DEPTH-1].
// Zero-fills itself after reset or on clr; requests are ignored while filling.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zero-fill walking cnt_q 0..DEPTH-1, busy=1, requests dropped
// ST_IDLE  | accepting single-cycle read/write requests, busy=0
module rw_mapped_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BASE   = 128,
  parameter int DEPTH  = 96
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   FIRST_A  = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]   LAST_A   = (ADDR_W+1)'(BASE + DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   addr_ext;
  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // Extra MSB keeps the upper-bound compare safe when the window ends at the top of the map.
  assign addr_ext = {1'b0, address};
  assign hit      = (addr_ext >= FIRST_A) && (addr_ext <= LAST_A);
  assign idx      = IDX_W'(address - ADDR_W'(BASE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = idx;
    mem_wdata  = data_in;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        // clr wins over a same-cycle request; the request is dropped entirely.
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (req) begin
          if (!hit) begin
            err_d = 1'b1;
          end else if (WE) begin
            mem_we = 1'b1;
          end else begin
            data_out_d = mem[idx];
            rd_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset; the fill sequence is the only way contents get cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_rw_mapped_ram.sv
// Bench for rw_mapped_ram: default instance checked against an array model,
// plus a 16-bit instance with a window at 0x40..0x5F.
module tb_rw_mapped_ram;

  logic       clk;
  logic       reset_n;
  logic       req, WE, clr;
  logic [7:0] address, data_in;
  logic [7:0] data_out;
  logic       rd_valid, err, busy;

  logic        b_reset_n;
  logic        b_req, b_we, b_clr;
  logic [7:0]  b_address;
  logic [15:0] b_data_in, b_data_out;
  logic        b_rd_valid, b_err, b_busy;

  rw_mapped_ram dut_a (
    .clk(clk), .reset_n(reset_n), .req(req), .WE(WE), .address(address),
    .data_in(data_in), .clr(clr), .data_out(data_out), .rd_valid(rd_valid),
    .err(err), .busy(busy)
  );

  rw_mapped_ram #(.DATA_W(16), .ADDR_W(8), .BASE(8'h40), .DEPTH(32)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .req(b_req), .WE(b_we), .address(b_address),
    .data_in(b_data_in), .clr(b_clr), .data_out(b_data_out), .rd_valid(b_rd_valid),
    .err(b_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model for the default instance: window 128..223, 96 words.
  int model [96];
  int exp_dout;
  int busy_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic w, input int addr, input int din,
                       input logic c, input string tag);
    logic exp_rv, exp_err;
    exp_rv  = 1'b0;
    exp_err = 1'b0;
    req     = r;
    WE      = w;
    address = addr[7:0];
    data_in = din[7:0];
    clr     = c;
    if (busy_left > 0) begin
      if (c) busy_left = 96;
      else   busy_left--;
    end else if (c) begin
      busy_left = 96;
      foreach (model[i]) model[i] = 0;
    end else if (r) begin
      if (addr < 128 || addr > 223) exp_err = 1'b1;
      else if (w) model[addr-128] = din & 8'hFF;
      else begin
        exp_dout = model[addr-128];
        exp_rv   = 1'b1;
      end
    end
    tick();
    check({tag, ".rd_valid"}, rd_valid, exp_rv);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".data_out"}, data_out, exp_dout);
    check({tag, ".busy"}, busy, busy_left > 0);
    req = 1'b0;
    WE  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    req     = 1'b0;
    clr     = 1'b0;
    #1;
    check("rst.data_out", data_out, 0);
    check("rst.rd_valid", rd_valid, 0);
    check("rst.err", err, 0);
    check("rst.busy", busy, 1);
    repeat (hold) tick();
    reset_n   = 1'b1;
    busy_left = 96;
    exp_dout  = 0;
    foreach (model[i]) model[i] = 0;
  endtask

  task automatic wait_fill(input string tag, input int first_addr);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (n == 0 && first_addr >= 0) apply(1'b1, 1'b0, first_addr, 0, 1'b0, {tag, ".busyreq"});
      else                           apply(1'b0, 1'b0, 0, 0, 1'b0, tag);
      n++;
    end
    check({tag, ".fill_cycles"}, n, 96);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    req = 0; WE = 0; clr = 0; address = 0; data_in = 0;
    b_req = 0; b_we = 0; b_clr = 0; b_address = 0; b_data_in = 0;
    b_reset_n = 1'b0;
    exp_dout = 0;
    busy_left = 96;

    // Power-up reset and automatic fill.
    do_reset(2);
    wait_fill("fill0", -1);

    for (int a = 128; a <= 223; a++) apply(1'b1, 1'b0, a, 0, 1'b0, "zero_rd");

    // Window edges.
    apply(1'b1, 1'b1, 128, 8'hA5, 1'b0, "wr128");
    apply(1'b1, 1'b1, 223, 8'h3C, 1'b0, "wr223");
    apply(1'b1, 1'b0, 128, 0, 1'b0, "rd128");
    check("rd128.const", data_out, 8'hA5);
    apply(1'b1, 1'b0, 223, 0, 1'b0, "rd223");
    check("rd223.const", data_out, 8'h3C);

    // Out-of-window accesses leave array and data_out alone.
    apply(1'b1, 1'b1, 127, 8'h77, 1'b0, "wr127");
    apply(1'b0, 1'b0, 0, 0, 1'b0, "after_err");
    apply(1'b1, 1'b0, 224, 0, 1'b0, "rd224");
    apply(1'b1, 1'b1, 224, 8'h11, 1'b0, "wr224");
    apply(1'b1, 1'b0, 127, 0, 1'b0, "rd127");
    apply(1'b1, 1'b0, 128, 0, 1'b0, "rd128b");
    apply(1'b1, 1'b0, 223, 0, 1'b0, "rd223b");

    // Write right after read of same word does not disturb returned data.
    apply(1'b1, 1'b1, 130, 8'h12, 1'b0, "wr130");
    apply(1'b1, 1'b0, 130, 0, 1'b0, "rd130");
    apply(1'b1, 1'b1, 130, 8'h99, 1'b0, "wr130b");
    check("raw.const", data_out, 8'h12);
    apply(1'b1, 1'b0, 130, 0, 1'b0, "rd130b");

    // clr drops a simultaneous write and zero-fills.
    apply(1'b1, 1'b1, 150, 8'h55, 1'b0, "wr150");
    apply(1'b1, 1'b1, 151, 8'hFF, 1'b1, "clr_wr151");
    wait_fill("fill_clr", -1);
    apply(1'b1, 1'b0, 150, 0, 1'b0, "rd150");
    check("rd150.const", data_out, 0);
    apply(1'b1, 1'b0, 151, 0, 1'b0, "rd151");
    check("rd151.const", data_out, 0);

    // clr during fill restarts it.
    apply(1'b0, 1'b0, 0, 0, 1'b1, "clr1");
    repeat (20) apply(1'b0, 1'b0, 0, 0, 1'b0, "fill_mid");
    apply(1'b0, 1'b0, 0, 0, 1'b1, "clr_restart");
    wait_fill("fill_restart", -1);

    // Reset at fill index 40 restarts the whole fill.
    apply(1'b1, 1'b1, 140, 8'h42, 1'b0, "wr140");
    apply(1'b0, 1'b0, 0, 0, 1'b1, "clr2");
    repeat (40) apply(1'b0, 1'b0, 0, 0, 1'b0, "fill40");
    do_reset(2);
    wait_fill("fill_rst", 200);
    apply(1'b1, 1'b0, 140, 0, 1'b0, "rd140");

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      int op, a, d;
      op = $urandom_range(0, 99);
      a  = $urandom_range(110, 240);
      d  = $urandom_range(0, 255);
      if (op < 45)      apply(1'b1, 1'b1, a, d, 1'b0, "rnd_wr");
      else if (op < 85) apply(1'b1, 1'b0, a, d, 1'b0, "rnd_rd");
      else if (op < 98) apply(1'b0, op[0], a, d, 1'b0, "rnd_idle");
      else              apply(1'b1, op[0], a, d, 1'b1, "rnd_clr");
    end

    // 16-bit instance, window 0x40..0x5F.
    b_reset_n = 1'b1;
    n = 0;
    while (b_busy && n < 100) begin
      tick();
      n++;
    end
    check("b.fill_cycles", n, 32);
    b_req = 1; b_we = 1; b_address = 8'h5F; b_data_in = 16'hBEEF;
    tick();
    check("b.wr.rd_valid", b_rd_valid, 0);
    check("b.wr.err", b_err, 0);
    b_we = 0;
    tick();
    check("b.rd.data_out", b_data_out, 16'hBEEF);
    check("b.rd.rd_valid", b_rd_valid, 1);
    b_address = 8'h40;
    tick();
    check("b.rd40.data_out", b_data_out, 0);
    b_address = 8'h60;
    tick();
    check("b.rd60.err", b_err, 1);
    check("b.rd60.rd_valid", b_rd_valid, 0);
    check("b.rd60.data_out", b_data_out, 0);
    b_address = 8'h3F; b_we = 1; b_data_in = 16'h1234;
    tick();
    check("b.wr3f.err", b_err, 1);
    b_req = 0; b_we = 0;
    tick();
    check("b.idle.err", b_err, 0);
    b_req = 1; b_address = 8'h5F;
    tick();
    check("b.rd5f.data_out", b_data_out, 16'hBEEF);
    b_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rw_mapped_ram.md
RW_MAPPED_RAM -- requirements
Module: rw_mapped_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8: bus address width in bits.
REQ-003 SHALL have parameter BASE, default 128: first bus address mapped to the array.
REQ-004 SHALL have parameter DEPTH, default 96: number of words; BASE+DEPTH <= 2**ADDR_W and DEPTH >= 2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  access request strobe, sampled on posedge clk.
REQ-008 SHALL have port WE  input  1  1 = write, 0 = read; qualified by req.
REQ-009 SHALL have port address  input  ADDR_W  bus address.
REQ-010 SHALL have port data_in  input  DATA_W  write data.
REQ-011 SHALL have port clr  input  1  pulse requesting a full zero-fill of the array.
REQ-012 SHALL have port data_out  output  DATA_W  registered read data.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse; data_out updated this cycle.
REQ-014 SHALL have port err  output  1  one-cycle pulse; the previous request fell outside the mapped range.
REQ-015 SHALL have port busy  output  1  zero-fill in progress; requests are ignored.

Function
REQ-016 SHALL decode hit = (address >= BASE) && (address <= BASE+DEPTH-1); local index = address - BASE, truncated to ceil(log2(DEPTH)) bits.
REQ-017 SHALL implement a two-state FSM: CLEAR (busy=1) and IDLE (busy=0).
REQ-018 In CLEAR, each posedge SHALL write 0 to the word at the fill counter, then increment the counter; after writing index DEPTH-1 the FSM SHALL go to IDLE.
REQ-019 In IDLE, when req=1, WE=1 and hit=1, the array SHALL store data_in at the local index on that posedge.
REQ-020 In IDLE, when req=1, WE=0 and hit=1, the block SHALL load data_out from the local index on that posedge and assert rd_valid for exactly that following cycle (1-cycle read latency).
REQ-021 In IDLE, when req=1 and hit=0, the block SHALL NOT change the array or data_out, and SHALL assert err for one cycle.
REQ-022 data_out SHALL hold its last value whenever no read is accepted; rd_valid and err SHALL be 0 otherwise.
REQ-023 A read and a write SHALL never be accepted in the same cycle; WE selects the operation.
REQ-024 clr=1 in IDLE SHALL move the FSM to CLEAR with the counter at 0 on the next posedge; a req in the same cycle SHALL be dropped (no write, no rd_valid, no err).
REQ-025 clr=1 during CLEAR SHALL restart the fill counter at 0.
REQ-026 A req while busy=1 SHALL be ignored silently: no array change, no rd_valid, no err.
REQ-027 A write to the same index in the cycle immediately following a read SHALL NOT alter the already-returned data_out.

Reset
REQ-028 While reset_n=0, the block SHALL force data_out=0, rd_valid=0, err=0, the FSM to CLEAR, the fill counter to 0, and busy=1, independent of clk.
REQ-029 After reset_n rises, the block SHALL zero-fill the array automatically; busy SHALL fall after exactly DEPTH posedges.
REQ-030 Reset asserted mid-fill or mid-access SHALL abort it and restart the zero-fill from index 0 on release.
REQ-031 The array contents SHALL NOT be reset asynchronously; only the zero-fill sequence clears them.

Verification
REQ-032 Release reset, idle: busy=1 for 96 cycles then 0; reading every address 128..223 SHALL return 0x00 with rd_valid pulses.
REQ-033 Write 0xA5 at 128 and 0x3C at 223, then read both: data_out SHALL be 0xA5 then 0x3C, each one cycle after its request.
REQ-034 Read or write at address 127 and at 224: err SHALL pulse once, rd_valid SHALL stay 0, and the array and data_out SHALL stay unchanged.
REQ-035 Write 0x55 at 150, pulse clr with a simultaneous write 0xFF at 151, then read 150 and 151 after busy falls: both SHALL return 0x00; busy SHALL stay high 96 cycles.
REQ-036 Assert reset_n=0 at fill index 40, hold 2 cycles, release: busy SHALL stay high for a full 96 cycles after release, and a request at address 200 during the fill SHALL produce no rd_valid and no err.
REQ-037 Instance with DATA_W=16, BASE=0x40, DEPTH=32, ADDR_W=8: write 0xBEEF at 0x5F and read it back, giving 0xBEEF; an access at 0x60 SHALL give err.
